// File: rtl/and2_pkg.sv
// Shared constants and types for the registered 2-input AND leaf block.
package and2_pkg;

  localparam int unsigned AND2_WIDTH_DEFAULT = 1;
  localparam int unsigned AND2_WIDTH_MAX     = 64;

  typedef logic [AND2_WIDTH_MAX-1:0] and2_word_t;

  // True when a requested operand width is inside the supported range.
  function automatic logic and2_width_ok(input int unsigned w);
    return (w >= 1) && (w <= AND2_WIDTH_MAX);
  endfunction

endpackage : and2_pkg

// File: rtl/and2_bit_cell.sv
// One bit-lane of and2_reg: 1-bit AND, hold mux and a flop with a
// synchronous active-low clear.
module and2_bit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic x_o
);

  logic x_d;
  logic x_q;

  // Next lane value: fresh product when enabled, otherwise hold.
  always_comb begin
    x_d = x_q;
    if (en_i) begin
      x_d = a_i & b_i;
    end
  end

  // Lane register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= 1'b0;
    end else begin
      x_q <= x_d;
    end
  end

  assign x_o = x_q;

endmodule : and2_bit_cell

// File: rtl/and2_reg.sv
// Registered, parameterised 2-input bitwise AND (x = a & b), one cycle of
// latency, one result per cycle, no backpressure.
// Optional feature macro: AND2_REG_ALL_ONES_EN adds a registered all_ones
// output equal to &(a & b) captured together with x.
module and2_reg
  import and2_pkg::*;
#(
  parameter int unsigned WIDTH = AND2_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic             out_valid
`ifdef AND2_REG_ALL_ONES_EN
  ,
  output logic             all_ones
`endif
);

  // Per-lane datapath; a lane whose inputs are known is never disturbed by
  // unknowns on a neighbouring lane because each lane is its own cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    and2_bit_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (in_valid),
      .a_i   (a[i]),
      .b_i   (b[i]),
      .x_o   (x[i])
    );
  end

  logic out_valid_d;
  logic out_valid_q;

  // Result is valid exactly on the cycle after an accepted input.
  always_comb begin
    out_valid_d = in_valid;
  end

  // Valid flag register; reset overrides in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

`ifdef AND2_REG_ALL_ONES_EN
  logic all_ones_d;
  logic all_ones_q;

  // Reduction of the fresh product, held alongside x when idle.
  always_comb begin
    all_ones_d = all_ones_q;
    if (in_valid) begin
      all_ones_d = &(a & b);
    end
  end

  // all_ones register, cleared with the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_ones_q <= 1'b0;
    end else begin
      all_ones_q <= all_ones_d;
    end
  end

  assign all_ones = all_ones_q;
`endif

  // Operand width must stay inside the supported range.
  a_width_ok : assert property (@(posedge clk) and2_width_ok(WIDTH));

endmodule : and2_reg

// File: tb/tb_and2_reg.sv
// Bench for and2_reg: three instances (WIDTH 1, 8, 16) driven from one
// stimulus process, checked every cycle against a history-based model plus
// directed literal expectations.
module tb_and2_reg;
  import and2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic v1, a1, b1, x1, ov1;
  logic v8, ov8;
  logic [7:0] a8, b8, x8;
  logic v16, ov16;
  logic [15:0] a16, b16, x16;
`ifdef AND2_REG_ALL_ONES_EN
  logic ao1, ao8, ao16;
`endif

  int asserts = 0;
  int fails   = 0;

  and2_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .x(x1), .out_valid(ov1)
`ifdef AND2_REG_ALL_ONES_EN
    , .all_ones(ao1)
`endif
  );

  and2_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .x(x8), .out_valid(ov8)
`ifdef AND2_REG_ALL_ONES_EN
    , .all_ones(ao8)
`endif
  );

  and2_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .a(a16), .b(b16),
    .x(x16), .out_valid(ov16)
`ifdef AND2_REG_ALL_ONES_EN
    , .all_ones(ao16)
`endif
  );

  // Model: a log of every edge (reset?, valid?, a&b). The expected output is
  // read off that log: out_valid from the latest edge, x from the most recent
  // accepted product since the last reset.
  typedef struct {
    bit         rst;
    bit         v;
    and2_word_t ab;
  } sample_t;

  sample_t hist[3][$];

  always @(posedge clk) begin
    hist[0].push_back('{rst: !rst_n, v: v1,  ab: and2_word_t'(a1 & b1)});
    hist[1].push_back('{rst: !rst_n, v: v8,  ab: and2_word_t'(a8 & b8)});
    hist[2].push_back('{rst: !rst_n, v: v16, ab: and2_word_t'(a16 & b16)});
  end

  function automatic and2_word_t lane_mask(input int unsigned w);
    and2_word_t m;
    m = '0;
    for (int unsigned i = 0; i < w; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic void model(input int k, output bit have, output logic ev,
                                output and2_word_t ex, output bit kn);
    have = 0; ev = 1'b0; ex = '0; kn = 0;
    if (hist[k].size() == 0) return;
    have = 1;
    ev = hist[k][$].v && !hist[k][$].rst;
    for (int i = hist[k].size() - 1; i >= 0; i--) begin
      if (hist[k][i].rst) begin ex = '0; kn = 1; return; end
      if (hist[k][i].v)   begin ex = hist[k][i].ab; kn = 1; return; end
    end
  endfunction

  task automatic check(input string name, input and2_word_t act, input and2_word_t exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k, input int unsigned w, input and2_word_t ax,
                         input logic av, input logic aao);
    bit have, kn;
    logic ev;
    and2_word_t ex, m;
    model(k, have, ev, ex, kn);
    if (!have) return;
    m = lane_mask(w);
    check($sformatf("w%0d out_valid", w), and2_word_t'(av), and2_word_t'(ev));
    if (kn) begin
      check($sformatf("w%0d x", w), ax & m, ex & m);
`ifdef AND2_REG_ALL_ONES_EN
      check($sformatf("w%0d all_ones", w), and2_word_t'(aao),
            and2_word_t'((ex & m) == m));
`else
      if (aao) $display("note: unused all_ones tie-off set");
`endif
    end
  endtask

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
`ifdef AND2_REG_ALL_ONES_EN
    cmp_one(0, 1,  and2_word_t'(x1),  ov1,  ao1);
    cmp_one(1, 8,  and2_word_t'(x8),  ov8,  ao8);
    cmp_one(2, 16, and2_word_t'(x16), ov16, ao16);
`else
    cmp_one(0, 1,  and2_word_t'(x1),  ov1,  1'b0);
    cmp_one(1, 8,  and2_word_t'(x8),  ov8,  1'b0);
    cmp_one(2, 16, and2_word_t'(x16), ov16, 1'b0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ta, tbv, tx;
    ta = 4'b1010; tbv = 4'b1100; tx = 4'b1000;   // bit i = pattern i: 00,10,01,11

    // Reset held for two edges with all inputs active.
    rst_n = 1'b0;
    v1 = 1'b1;  a1 = 1'b1;  b1 = 1'b1;
    v8 = 1'b1;  a8 = '1;    b8 = '1;
    v16 = 1'b1; a16 = '1;   b16 = '1;
    step(); step();
    check("reset w1 x",   and2_word_t'(x1),   '0);
    check("reset w1 ov",  and2_word_t'(ov1),  '0);
    check("reset w8 x",   and2_word_t'(x8),   '0);
    check("reset w8 ov",  and2_word_t'(ov8),  '0);
    check("reset w16 x",  and2_word_t'(x16),  '0);
    check("reset w16 ov", and2_word_t'(ov16), '0);

    rst_n = 1'b1; v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    step();

    // Truth table on the 1-bit instance, back to back.
    v1 = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      a1 = ta[i]; b1 = tbv[i];
      step();
      check($sformatf("truth %0d x", i), and2_word_t'(x1), and2_word_t'(tx[i]));
      check($sformatf("truth %0d ov", i), and2_word_t'(ov1), 64'd1);
    end
    v1 = 1'b0;

    // Hold behaviour.
    v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    step();
    check("hold load x", and2_word_t'(x8), 64'h30);
    check("hold load ov", and2_word_t'(ov8), 64'd1);
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold %0d x", i), and2_word_t'(x8), 64'h30);
      check($sformatf("hold %0d ov", i), and2_word_t'(ov8), 64'd0);
    end

    // Mid-stream reset discards the pending result.
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    step();
    check("pre-reset x", and2_word_t'(x8), 64'hFF);
    rst_n = 1'b0;
    step();
    check("mid-reset x", and2_word_t'(x8), 64'h0);
    check("mid-reset ov", and2_word_t'(ov8), 64'd0);
    rst_n = 1'b1; v8 = 1'b0;
    step();
    check("post-reset idle ov", and2_word_t'(ov8), 64'd0);
    check("post-reset idle x", and2_word_t'(x8), 64'h0);
    v8 = 1'b1; a8 = 8'h0F; b8 = 8'hFF;
    step();
    check("post-reset first x", and2_word_t'(x8), 64'h0F);
    check("post-reset first ov", and2_word_t'(ov8), 64'd1);

`ifdef AND2_REG_ALL_ONES_EN
    a8 = 8'hFF; b8 = 8'hFF;
    step();
    check("all_ones full", and2_word_t'(ao8), 64'd1);
    a8 = 8'hFF; b8 = 8'hFE;
    step();
    check("all_ones miss", and2_word_t'(ao8), 64'd0);
    check("all_ones miss x", and2_word_t'(x8), 64'hFE);
`endif
    v8 = 1'b0;

    // Random traffic on all instances with occasional resets.
    for (int unsigned n = 0; n < 1000; n++) begin
      rst_n = ($urandom_range(63) != 0);
      v1  = 1'($urandom); a1  = 1'($urandom);  b1  = 1'($urandom);
      v8  = 1'($urandom); a8  = 8'($urandom);  b8  = 8'($urandom);
      v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      step();
    end

    rst_n = 1'b1; v1 = 1'b0; v8 = 1'b0; v16 = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule : tb_and2_reg
